// File: rtl/count_tracker.sv
// Receive-side checker for a free-running up-counter: verifies each enabled
// sample is the previous one plus 1 (mod 2^Size), locks on a clean run, and reports errors.
module count_tracker #(
  parameter int Size       = 5,
  parameter int LockCycles = 4,
  parameter int LossLimit  = 3,
  parameter int ErrWidth   = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic [Size-1:0]     count,
  input  logic                err_clear,
  output logic                locked,
  output logic                error,
  output logic                wrap,
  output logic [ErrWidth-1:0] err_count,
  output logic [1:0]          state
);

  localparam logic [1:0] HUNT    = 2'd0;
  localparam logic [1:0] SYNC    = 2'd1;
  localparam logic [1:0] LOCK    = 2'd2;
  localparam logic [1:0] ILLEGAL = 2'd3;

  localparam logic [7:0]          LOCK_TGT = 8'(LockCycles);
  localparam logic [7:0]          LOSS_TGT = 8'(LossLimit);
  localparam logic [Size-1:0]     CNT_MAX  = {Size{1'b1}};
  localparam logic [ErrWidth-1:0] ERR_MAX  = {ErrWidth{1'b1}};

  logic [1:0]          state_q,  state_d;
  logic [Size-1:0]     prev_q,   prev_d;
  logic [7:0]          good_q,   good_d;
  logic [7:0]          bad_q,    bad_d;
  logic [ErrWidth-1:0] err_q,    err_d;
  logic                error_q,  error_d;
  logic                wrap_q,   wrap_d;
  logic                locked_q, locked_d;

  logic [Size-1:0]     expected_s;
  logic                match_s;
  logic                hit_s;

  // A clear coincident with a new mismatch leaves exactly that one mismatch counted.
  function automatic logic [ErrWidth-1:0] err_next(
    input logic [ErrWidth-1:0] cur,
    input logic                hit,
    input logic                clr
  );
    logic [ErrWidth-1:0] res;
    if (clr) begin
      res = hit ? {{(ErrWidth-1){1'b0}}, 1'b1} : {ErrWidth{1'b0}};
    end else if (hit && (cur != ERR_MAX)) begin
      res = cur + {{(ErrWidth-1){1'b0}}, 1'b1};
    end else begin
      res = cur;
    end
    return res;
  endfunction

  assign expected_s = prev_q + Size'(1'b1);
  assign match_s    = (count == expected_s);

  // Next-state logic for the HUNT/SYNC/LOCK tracker and its pulse outputs.
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    good_d  = good_q;
    bad_d   = bad_q;
    error_d = 1'b0;
    wrap_d  = 1'b0;
    hit_s   = 1'b0;
    if (enable) begin
      case (state_q)
        HUNT: begin
          prev_d  = count;
          good_d  = 8'd0;
          state_d = SYNC;
        end
        SYNC: begin
          prev_d = count;
          if (match_s) begin
            good_d = good_q + 8'd1;
            if ((good_q + 8'd1) == LOCK_TGT) begin
              state_d = LOCK;
              bad_d   = 8'd0;
            end else begin
              state_d = SYNC;
            end
          end else begin
            good_d = 8'd0;
          end
        end
        LOCK: begin
          if (match_s) begin
            prev_d = count;
            bad_d  = 8'd0;
            wrap_d = (prev_q == CNT_MAX);
          end else begin
            // Flywheel on the predicted value so one glitch costs one error.
            prev_d  = expected_s;
            error_d = 1'b1;
            hit_s   = 1'b1;
            bad_d   = bad_q + 8'd1;
            if ((bad_q + 8'd1) == LOSS_TGT) begin
              state_d = HUNT;
              good_d  = 8'd0;
            end else begin
              state_d = LOCK;
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end else begin
      if (state_q == ILLEGAL) begin
        state_d = HUNT;
      end else begin
        state_d = state_q;
      end
    end
    err_d    = err_next(err_q, hit_s, err_clear);
    locked_d = (state_d == LOCK);
  end

  // State and status registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= HUNT;
      prev_q   <= {Size{1'b0}};
      good_q   <= 8'd0;
      bad_q    <= 8'd0;
      err_q    <= {ErrWidth{1'b0}};
      error_q  <= 1'b0;
      wrap_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      err_q    <= err_d;
      error_q  <= error_d;
      wrap_q   <= wrap_d;
      locked_q <= locked_d;
    end
  end

  assign state     = state_q;
  assign locked    = locked_q;
  assign error     = error_q;
  assign wrap      = wrap_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_count_tracker.sv
// Self-checking bench for count_tracker: directed scenarios plus random traffic,
// compared against a behavioural model; two instances differ only in error-counter width.
module tb_count_tracker;

  localparam int SIZE     = 5;
  localparam int LOCK_CYC = 4;
  localparam int LOSS     = 3;
  localparam int MODV     = 1 << SIZE;

  logic       clock     = 1'b0;
  logic       reset     = 1'b0;
  logic       enable    = 1'b0;
  logic [4:0] count     = 5'd0;
  logic       err_clear = 1'b0;

  logic       locked_a, error_a, wrap_a;
  logic [7:0] err_a;
  logic [1:0] state_a;
  logic       locked_b, error_b, wrap_b;
  logic [1:0] err_b;
  logic [1:0] state_b;

  int checks = 0;
  int errors = 0;

  // Behavioural model: mode 0=HUNT 1=SYNC 2=LOCK, plus an unsaturated error tally.
  int m_mode, m_prev, m_good, m_bad, m_errs, m_error, m_wrap;
  int err_pulses, wrap_pulses;

  count_tracker #(.Size(SIZE), .LockCycles(LOCK_CYC), .LossLimit(LOSS), .ErrWidth(8)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .count(count), .err_clear(err_clear),
    .locked(locked_a), .error(error_a), .wrap(wrap_a), .err_count(err_a), .state(state_a)
  );

  count_tracker #(.Size(SIZE), .LockCycles(LOCK_CYC), .LossLimit(LOSS), .ErrWidth(2)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .count(count), .err_clear(err_clear),
    .locked(locked_b), .error(error_b), .wrap(wrap_b), .err_count(err_b), .state(state_b)
  );

  always #5 clock = ~clock;

  function automatic int sat(input int n, input int mx);
    return (n > mx) ? mx : n;
  endfunction

  function automatic int nxt();
    return (m_prev + 1) % MODV;
  endfunction

  function automatic int bad_val();
    return (nxt() + 1 + int'($urandom_range(0, MODV - 3))) % MODV;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_good = 0; m_bad = 0; m_errs = 0; m_error = 0; m_wrap = 0;
  endtask

  task automatic model_edge(input bit en, input int v, input bit clr);
    int want;
    m_error = 0;
    m_wrap  = 0;
    if (en) begin
      want = (m_prev + 1) % MODV;
      if (m_mode == 0) begin
        m_prev = v; m_good = 0; m_mode = 1;
      end else if (m_mode == 1) begin
        if (v == want) begin
          m_good++;
          if (m_good == LOCK_CYC) begin m_mode = 2; m_bad = 0; end
        end else begin
          m_good = 0;
        end
        m_prev = v;
      end else begin
        if (v == want) begin
          m_wrap = (m_prev == MODV - 1) ? 1 : 0;
          m_prev = v; m_bad = 0;
        end else begin
          m_error = 1; m_prev = want; m_bad++;
          if (m_bad == LOSS) begin m_mode = 0; m_good = 0; end
        end
      end
    end
    m_errs = clr ? m_error : m_errs + m_error;
  endtask

  task automatic chk(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic check_all();
    chk("state_a",  int'(state_a),  m_mode);
    chk("state_b",  int'(state_b),  m_mode);
    chk("locked_a", int'(locked_a), (m_mode == 2) ? 1 : 0);
    chk("locked_b", int'(locked_b), (m_mode == 2) ? 1 : 0);
    chk("error_a",  int'(error_a),  m_error);
    chk("error_b",  int'(error_b),  m_error);
    chk("wrap_a",   int'(wrap_a),   m_wrap);
    chk("wrap_b",   int'(wrap_b),   m_wrap);
    chk("err_a",    int'(err_a),    sat(m_errs, 255));
    chk("err_b",    int'(err_b),    sat(m_errs, 3));
  endtask

  task automatic step(input bit en, input int v, input bit clr);
    enable    = en;
    count     = 5'(v);
    err_clear = clr;
    @(posedge clock);
    model_edge(en, v, clr);
    #1;
    check_all();
    err_pulses  += int'(error_a);
    wrap_pulses += int'(wrap_a);
  endtask

  task automatic relock();
    step(1'b1, int'($urandom_range(0, MODV - 1)), 1'b0);
    for (int k = 0; k < LOCK_CYC; k++) step(1'b1, nxt(), 1'b0);
  endtask

  initial begin
    model_reset();
    err_pulses  = 0;
    wrap_pulses = 0;

    // Reset values while reset is held through two edges.
    #2;
    check_all();
    for (int k = 0; k < 2; k++) begin
      @(posedge clock);
      #1;
      check_all();
    end
    reset = 1'b1;

    // Clean ramp through the 31 -> 0 boundary.
    for (int i = 0; i <= 40; i++) begin
      step(1'b1, i % MODV, 1'b0);
      if (i == 0) chk("hunt_to_sync", int'(state_a), 1);
      if (i == 3) chk("not_locked_at_3", int'(locked_a), 0);
      if (i == 4) chk("locked_at_4", int'(locked_a), 1);
    end
    chk("wrap_once", wrap_pulses, 1);
    chk("ramp_no_error", err_pulses, 0);

    // Isolated glitch costs exactly one error.
    err_pulses = 0;
    step(1'b1, nxt(), 1'b0);
    step(1'b1, bad_val(), 1'b0);
    for (int k = 0; k < 3; k++) step(1'b1, (m_prev + 1) % MODV, 1'b0);
    chk("glitch_pulses", err_pulses, 1);
    chk("glitch_errcnt", int'(err_a), 1);
    chk("glitch_locked", int'(locked_a), 1);

    // Loss of lock after three consecutive mismatches, then relock.
    for (int k = 0; k < LOSS; k++) step(1'b1, bad_val(), 1'b0);
    chk("loss_state", int'(state_a), 0);
    chk("loss_errcnt", int'(err_a), 4);
    relock();
    chk("relock", int'(locked_a), 1);

    // Drive enough mismatches to saturate the narrow counter.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < LOSS; k++) step(1'b1, bad_val(), 1'b0);
      relock();
    end
    chk("sat_narrow", int'(err_b), 3);
    chk("wide_count", int'(err_a), 10);

    // Clear coincident with an error, then clear alone.
    step(1'b1, bad_val(), 1'b1);
    chk("clr_with_err", int'(err_b), 1);
    step(1'b1, nxt(), 1'b0);
    step(1'b1, nxt(), 1'b1);
    chk("clr_alone", int'(err_a), 0);

    // Enable low with garbage on the bus: nothing moves.
    for (int k = 0; k < 10; k++) step(1'b0, int'($urandom_range(0, MODV - 1)), 1'b0);
    chk("hold_locked", int'(locked_a), 1);

    // Asynchronous reset in the middle of LOCK.
    step(1'b1, nxt(), 1'b0);
    reset = 1'b0;
    #2;
    model_reset();
    check_all();
    reset = 1'b1;
    relock();
    chk("relock_after_reset", int'(locked_a), 1);

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      bit en, clr;
      int v;
      en  = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 15) == 0);
      v   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, MODV - 1)) : nxt();
      step(en, v, clr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_tracker.md
Name: count_tracker

Overview:
- Receive-side companion to the free-running up-counter.
- Samples the counter's `count` bus and checks that each sample is exactly the previous value plus 1, modulo 2^Size.
- Acquires lock after a run of good increments, then flags errors, wrap events and loss of lock.
- Sits beside the counter in the bench as a hardware self-check; the Ruby side reads its status outputs.

Parameters:
- Size, 5, width of the observed count bus (must match the counter's Size).
- LockCycles, 4, consecutive good increments needed to enter LOCK (1..255).
- LossLimit, 3, consecutive mismatches in LOCK that drop back to HUNT (1..255).
- ErrWidth, 8, width of the saturating error counter.

Ports:
- clock  input  1  sampling clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  count is valid this cycle; when low, nothing changes.
- count  input  Size  observed counter value.
- err_clear  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCK.
- error  output  1  one-cycle pulse per mismatch detected in LOCK.
- wrap  output  1  one-cycle pulse when a locked sample goes from 2^Size-1 to 0.
- err_count  output  ErrWidth  saturating count of mismatches.
- state  output  2  current state: HUNT=0, SYNC=1, LOCK=2.

Behaviour:
- Reset (reset low, asynchronous):
  - state=HUNT, locked=0, error=0, wrap=0, err_count=0.
  - Internal prev=0, good=0, bad=0.
  - Release is sampled on a clock edge.
- All outputs are registered. Effects of a sample appear in the cycle after the enabled edge.
- enable=0: state, prev, good and bad hold. error and wrap are 0.
- expected = (prev + 1) mod 2^Size. The comparison uses the full Size bits, so 2^Size-1 followed by 0 is a match.
- HUNT, on enable: prev<=count, good<=0, go to SYNC.
- SYNC, on enable:
  - If count==expected: good<=good+1.
  - If count!=expected: good<=0; stay in SYNC; no error pulse and no err_count change.
  - prev<=count in both cases.
  - When good+1==LockCycles on a match: go to LOCK, bad<=0.
- LOCK, on enable, match:
  - prev<=count, bad<=0.
  - wrap pulses if prev==2^Size-1.
- LOCK, on enable, mismatch:
  - error pulses; err_count increments, saturating at 2^ErrWidth-1.
  - Flywheel: prev<=expected, not count, so an isolated glitch costs exactly one error.
  - bad<=bad+1. When bad+1==LossLimit: go to HUNT, locked falls, good<=0.
  - The error pulse for the final mismatch is still issued.
- locked is high exactly when the registered state is LOCK.
- err_clear:
  - err_clear alone: err_count<=0.
  - err_clear in the same cycle as a new error: err_count<=1.
  - err_clear never affects state.
- Reset asserted mid-operation (any state) returns to the reset values immediately, with no pulse.
- Only HUNT, SYNC and LOCK are reachable. Encoding 3 is illegal and goes to HUNT on the next edge.

Test Plan:
- Reset, then a clean ramp 0,1,2,... with enable=1 (Size=5, LockCycles=4):
  - state goes HUNT→SYNC after sample 0.
  - locked rises after the edge sampling value 4.
  - error stays 0 throughout.
- Locked ramp through 31→0:
  - wrap pulses for exactly one cycle, after the edge that samples 0.
  - locked stays 1; err_count stays 0.
- Locked, inject a single glitch (…,10,27,12,13…):
  - exactly one error pulse; err_count=1; locked stays 1.
- Locked, three consecutive bad samples (LossLimit=3):
  - three error pulses; err_count=3.
  - state=HUNT after the third; locked=0.
  - lock is regained after 1 HUNT sample plus 4 good increments.
- ErrWidth=2, feed more than 5 mismatches by relocking repeatedly:
  - err_count saturates at 3.
  - err_clear coincident with an error gives err_count=1.
  - err_clear alone gives 0.
- Behaviour while locked:
  - enable low for 10 cycles with a garbage count: no change.
  - reset pulsed low mid-LOCK: all outputs zero immediately, then relock proceeds normally.
